// File: rtl/opl3_host_bus_master.sv
// opl3_host_bus_master: host-side initiator for the OPL3 4-address bus (register writes and status reads).
// Optional macro OPL3_BUS_ADDR_CACHE_EN skips the address cycle when {bank,address} repeats.
module opl3_host_bus_master #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int RECOVER_CYCLES  = 2,
    parameter int RD_SAMPLE_CYCLE = 2
) (
    input  logic       clk_host,
    input  logic       ic_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_bank,
    input  logic [7:0] wr_address,
    input  logic [7:0] wr_data,
    input  logic       rd_valid,
    output logic       rd_ready,
    output logic       rd_done,
    output logic [7:0] rd_data,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] address,
    output logic [7:0] dout,
    input  logic [7:0] din,
    output logic       busy
);

    localparam int MAXP = (SETUP_CYCLES > STROBE_CYCLES)
                          ? ((SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES : RECOVER_CYCLES)
                          : ((STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES);
    localparam int CW = $clog2(MAXP + 1);
    // A sample index past the strobe window falls back to the last strobe cycle.
    localparam int RD_IDX = (RD_SAMPLE_CYCLE < STROBE_CYCLES) ? RD_SAMPLE_CYCLE : STROBE_CYCLES - 1;
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(STROBE_CYCLES - 1 - RD_IDX);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, R_SETUP, R_STROBE, R_RECOV
    } state_e;

    function automatic logic [CW-1:0] phase_load(input state_e s);
        case (s)
            A_SETUP, D_SETUP, R_SETUP:    phase_load = CW'(SETUP_CYCLES - 1);
            A_STROBE, D_STROBE, R_STROBE: phase_load = CW'(STROBE_CYCLES - 1);
            A_RECOV, D_RECOV, R_RECOV:    phase_load = CW'(RECOVER_CYCLES - 1);
            default:                      phase_load = '0;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic [7:0]    addr_q, addr_d, data_q, data_d;
    logic          cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [1:0]    address_q, address_d;
    logic [7:0]    dout_q, dout_d;
    logic          ready_q, ready_d, rd_done_q, rd_done_d;
    logic [7:0]    rd_cap_q, rd_cap_d, rd_data_q, rd_data_d;
    logic          wr_acc, rd_acc, phase_end, cache_hit;

    assign wr_acc    = wr_valid && ready_q;
    assign rd_acc    = rd_valid && ready_q && !wr_valid;
    assign phase_end = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = phase_end ? cnt_q : cnt_q - 1'b1;
        bank_d  = bank_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    bank_d  = wr_bank;
                    addr_d  = wr_address;
                    data_d  = wr_data;
                    state_d = cache_hit ? D_SETUP : A_SETUP;
                end else if (rd_acc) begin
                    state_d = R_SETUP;
                end
            end
            A_SETUP:  if (phase_end) state_d = A_STROBE;
            A_STROBE: if (phase_end) state_d = A_RECOV;
            A_RECOV:  if (phase_end) state_d = D_SETUP;
            D_SETUP:  if (phase_end) state_d = D_STROBE;
            D_STROBE: if (phase_end) state_d = D_RECOV;
            D_RECOV:  if (phase_end) state_d = IDLE;
            R_SETUP:  if (phase_end) state_d = R_STROBE;
            R_STROBE: if (phase_end) state_d = R_RECOV;
            R_RECOV:  if (phase_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = phase_load(state_d);

        // Bus outputs are decoded from the next state so they register in step with it.
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        address_d = address_q;
        dout_d    = dout_q;
        case (state_d)
            A_SETUP: begin
                address_d = {bank_d, 1'b0};
                dout_d    = addr_d;
            end
            D_SETUP: begin
                address_d = {bank_d, 1'b1};
                dout_d    = data_d;
            end
            R_SETUP:  address_d = 2'b00;
            A_STROBE, D_STROBE: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
            end
            R_STROBE: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: ;
        endcase
        ready_d   = (state_d == IDLE);
        rd_done_d = (state_q == R_STROBE) && (state_d == R_RECOV);
        rd_cap_d  = ((state_q == R_STROBE) && (cnt_q == SAMPLE_CNT)) ? din : rd_cap_q;
        rd_data_d = rd_done_d ? rd_cap_d : rd_data_q;
    end

    always_ff @(posedge clk_host or negedge ic_n) begin
        if (!ic_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bank_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            address_q <= '0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            rd_done_q <= 1'b0;
            rd_cap_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            address_q <= address_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            rd_done_q <= rd_done_d;
            rd_cap_q  <= rd_cap_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef OPL3_BUS_ADDR_CACHE_EN
    logic       cache_vld_q, cache_vld_d;
    logic [8:0] cache_tag_q, cache_tag_d;

    assign cache_hit = cache_vld_q && (cache_tag_q == {wr_bank, wr_address});

    // Reads invalidate the cache so a bench resetting both bus sides stays in step.
    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_tag_d = cache_tag_q;
        if ((state_q == A_RECOV) && (state_d == D_SETUP)) begin
            cache_vld_d = 1'b1;
            cache_tag_d = {bank_q, addr_q};
        end
        if (rd_acc) cache_vld_d = 1'b0;
    end

    always_ff @(posedge clk_host or negedge ic_n) begin
        if (!ic_n) begin
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_tag_q <= cache_tag_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign wr_ready = ready_q;
    assign rd_ready = ready_q;
    assign rd_done  = rd_done_q;
    assign rd_data  = rd_data_q;
    assign cs_n     = cs_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;
    assign address  = address_q;
    assign dout     = dout_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_opl3_host_bus_master.sv
// Self-checking bench for opl3_host_bus_master: bus strobe runs are recorded and compared with
// transactions predicted from the bus protocol rules (honours OPL3_BUS_ADDR_CACHE_EN when defined).
module tb_opl3_host_bus_master;

    localparam int S  = 1;
    localparam int T  = 2;
    localparam int R  = 2;
    localparam int PH = S + T + R;

    logic       clk_host = 1'b0;
    logic       ic_n = 1'b0;
    logic       wr_valid = 1'b0, wr_bank = 1'b0, rd_valid = 1'b0;
    logic [7:0] wr_address = '0, wr_data = '0, din = '0;
    logic       wr_ready, rd_ready, rd_done, cs_n, rd_n, wr_n, busy;
    logic [7:0] rd_data, dout;
    logic [1:0] address;

    opl3_host_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .RECOVER_CYCLES(R),
                           .RD_SAMPLE_CYCLE(2)) dut (
        .clk_host(clk_host), .ic_n(ic_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_bank(wr_bank), .wr_address(wr_address), .wr_data(wr_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_done(rd_done), .rd_data(rd_data), .cs_n(cs_n), .rd_n(rd_n),
        .wr_n(wr_n), .address(address), .dout(dout), .din(din), .busy(busy));

    always #5 clk_host = ~clk_host;

    int unsigned cyc = 0;
    always @(posedge clk_host) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [7:0]  dout;
        int unsigned len;
        int unsigned start;
    } rec_t;

    rec_t       obs_q[$];
    rec_t       cur;
    bit         in_run = 0;
    int         rd_done_cnt = 0;
    int         unstable = 0;
    logic [7:0] rd_seen = '0;

    // Bus monitor: one record per contiguous cs_n-low run.
    initial begin
        forever begin
            @(negedge clk_host);
            if (!ic_n) begin
                in_run = 0;
            end else begin
                n_total++;
                if ((wr_n === 1'b0 && rd_n === 1'b0) || (wr_n === 1'b1 && rd_n === 1'b1 && cs_n !== 1'b1))
                    $display("FAIL strobe_exclusive: cs_n=%b wr_n=%b rd_n=%b, required one strobe with cs_n low or all high", cs_n, wr_n, rd_n);
                else n_pass++;
                if (cs_n === 1'b0) begin
                    if (!in_run) begin
                        cur.is_wr = (wr_n === 1'b0);
                        cur.addr  = address;
                        cur.dout  = dout;
                        cur.len   = 1;
                        cur.start = cyc;
                        in_run    = 1;
                    end else begin
                        cur.len++;
                        if (address !== cur.addr || dout !== cur.dout) unstable++;
                    end
                end else if (in_run) begin
                    obs_q.push_back(cur);
                    in_run = 0;
                end
                if (rd_done === 1'b1) begin
                    rd_done_cnt++;
                    rd_seen = rd_data;
                end
            end
        end
    end

`ifdef OPL3_BUS_ADDR_CACHE_EN
    bit         m_vld = 0;
    logic       m_bank = 1'b0;
    logic [7:0] m_addr = '0;
`endif

    // Reference: returns whether the write should skip its address cycle, then records it.
    function automatic bit model_wr(input logic b, input logic [7:0] a);
        bit hit = 0;
`ifdef OPL3_BUS_ADDR_CACHE_EN
        hit    = m_vld && (m_bank == b) && (m_addr == a);
        m_vld  = 1;
        m_bank = b;
        m_addr = a;
`endif
        return hit;
    endfunction

    task automatic model_clear();
`ifdef OPL3_BUS_ADDR_CACHE_EN
        m_vld = 0;
`endif
    endtask

    task automatic wait_ready();
        int t = 0;
        while (wr_ready !== 1'b1 && t < 100) begin
            @(negedge clk_host);
            t++;
        end
        if (t >= 100) begin
            n_total++;
            $display("FAIL ready_timeout: wr_ready=%b after %0d cycles, required 1", wr_ready, t);
        end
    endtask

    task automatic wait_idle(output int occ);
        int t = 0;
        occ = 0;
        while (busy === 1'b1 && t < 200) begin
            occ++;
            @(negedge clk_host);
            t++;
        end
        if (t >= 200) begin
            n_total++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, required low", t);
        end
    endtask

    task automatic do_write(input logic b, input logic [7:0] a, input logic [7:0] d,
                            output bit hit, output int occ);
        wait_ready();
        hit = model_wr(b, a);
        wr_bank = b; wr_address = a; wr_data = d; wr_valid = 1'b1;
        @(negedge clk_host);
        wr_valid = 1'b0;
        wait_idle(occ);
    endtask

    task automatic do_read(input logic [7:0] v, output int occ);
        wait_ready();
        model_clear();
        din = v; rd_valid = 1'b1;
        @(negedge clk_host);
        rd_valid = 1'b0;
        wait_idle(occ);
    endtask

    task automatic test_reset();
        n_total++;
        if ({cs_n, rd_n, wr_n} !== 3'b111) $display("FAIL reset_strobes: got %b, required 111", {cs_n, rd_n, wr_n});
        else n_pass++;
        n_total++;
        if ({address, dout, rd_data} !== 18'h0) $display("FAIL reset_data: address=%h dout=%h rd_data=%h, required 0", address, dout, rd_data);
        else n_pass++;
        n_total++;
        if ({rd_done, wr_ready, rd_ready, busy} !== 4'b0) $display("FAIL reset_ctrl: done/wrdy/rrdy/busy=%b, required 0000", {rd_done, wr_ready, rd_ready, busy});
        else n_pass++;
        ic_n = 1'b1;
        #1;
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL ready_after_release: got %b, required 0", wr_ready);
        else n_pass++;
        @(negedge clk_host);
        n_total++;
        if ({wr_ready, rd_ready, busy} !== 3'b110) $display("FAIL ready_idle: wrdy/rrdy/busy=%b, required 110", {wr_ready, rd_ready, busy});
        else n_pass++;
    endtask

    task automatic test_write_cases();
        logic       bks[3];
        logic [7:0] ads[3];
        logic [7:0] dts[3];
        bit         hit;
        int         occ, done0, ne;
        bks = '{1'b0, 1'b1, 1'b1};
        ads = '{8'h20, 8'h05, 8'h05};
        dts = '{8'h01, 8'h01, 8'h7E};
        for (int i = 0; i < 3; i++) begin
            obs_q.delete();
            done0 = rd_done_cnt;
            do_write(bks[i], ads[i], dts[i], hit, occ);
            ne = hit ? 1 : 2;
            n_total++;
            if (occ != ne * PH) $display("FAIL write%0d_occupancy: got %0d, required %0d", i, occ, ne * PH);
            else n_pass++;
            n_total++;
            if (obs_q.size() != ne) $display("FAIL write%0d_runs: got %0d strobe runs, required %0d", i, obs_q.size(), ne);
            else n_pass++;
            for (int k = 0; k < obs_q.size() && k < ne; k++) begin
                logic [1:0] ea = {bks[i], (hit || k == 1)};
                logic [7:0] ed = (hit || k == 1) ? dts[i] : ads[i];
                n_total++;
                if (!obs_q[k].is_wr || obs_q[k].addr !== ea || obs_q[k].dout !== ed || obs_q[k].len != T)
                    $display("FAIL write%0d_cycle%0d: wr=%0d addr=%b dout=%h len=%0d, required wr=1 addr=%b dout=%h len=%0d",
                             i, k, obs_q[k].is_wr, obs_q[k].addr, obs_q[k].dout, obs_q[k].len, ea, ed, T);
                else n_pass++;
            end
            if (ne == 2 && obs_q.size() == 2) begin
                n_total++;
                if (obs_q[1].start - obs_q[0].start != PH)
                    $display("FAIL write%0d_spacing: got %0d, required %0d", i, obs_q[1].start - obs_q[0].start, PH);
                else n_pass++;
            end
            n_total++;
            if (rd_done_cnt != done0) $display("FAIL write%0d_no_rd_done: got %0d pulses, required 0", i, rd_done_cnt - done0);
            else n_pass++;
        end
    endtask

    task automatic test_read();
        int occ, done0;
        obs_q.delete();
        done0 = rd_done_cnt;
        do_read(8'hE0, occ);
        n_total++;
        if (occ != PH) $display("FAIL read_occupancy: got %0d, required %0d", occ, PH);
        else n_pass++;
        n_total++;
        if (obs_q.size() != 1 || obs_q[0].is_wr || obs_q[0].addr !== 2'b00 || obs_q[0].len != T)
            $display("FAIL read_cycle: runs=%0d, required one rd_n run at address 0 of %0d cycles", obs_q.size(), T);
        else n_pass++;
        n_total++;
        if (rd_done_cnt - done0 != 1) $display("FAIL read_done_pulses: got %0d, required 1", rd_done_cnt - done0);
        else n_pass++;
        din = 8'h00;
        repeat (3) @(negedge clk_host);
        n_total++;
        if (rd_seen !== 8'hE0 || rd_data !== 8'hE0) $display("FAIL read_data: at done %h, held %h, required e0", rd_seen, rd_data);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int  occ, done0, t;
        bit  hit;
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        obs_q.delete();
        done0 = rd_done_cnt;
        wait_ready();
        hit = model_wr(1'b0, a);
        wr_bank = 1'b0; wr_address = a; wr_data = 8'h3C; wr_valid = 1'b1;
        rd_valid = 1'b1; din = 8'hA5;
        @(negedge clk_host);
        wr_valid = 1'b0;
        n_total++;
        if (rd_ready !== 1'b0) $display("FAIL simul_rd_ready: got %b, required 0 while write runs", rd_ready);
        else n_pass++;
        t = 0;
        while (rd_ready !== 1'b1 && t < 100) begin
            @(negedge clk_host);
            t++;
        end
        n_total++;
        if (t != (hit ? 1 : 2) * PH) $display("FAIL simul_rd_wait: rd_ready after %0d cycles, required %0d", t, (hit ? 1 : 2) * PH);
        else n_pass++;
        model_clear();
        @(negedge clk_host);
        rd_valid = 1'b0;
        wait_idle(occ);
        n_total++;
        if (obs_q.size() != (hit ? 2 : 3) || !obs_q[0].is_wr || obs_q[obs_q.size()-1].is_wr)
            $display("FAIL simul_order: got %0d runs, required write cycles then one read", obs_q.size());
        else n_pass++;
        n_total++;
        if (rd_done_cnt - done0 != 1 || rd_seen !== 8'hA5) $display("FAIL simul_read: pulses=%0d data=%h, required 1 and a5", rd_done_cnt - done0, rd_seen);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int  t, occ, done0;
        bit  hit;
        wait_ready();
        done0 = rd_done_cnt;
        wr_bank = 1'b0; wr_address = 8'h40; wr_data = 8'h99; wr_valid = 1'b1;
        @(negedge clk_host);
        wr_valid = 1'b0;
        t = 0;
        while (!(cs_n === 1'b0 && address === 2'b01) && t < 50) begin
            @(negedge clk_host);
            t++;
        end
        n_total++;
        if (t >= 50) $display("FAIL abort_reach_dstrobe: not seen after %0d cycles, required data strobe", t);
        else n_pass++;
        ic_n = 1'b0;
        #1;
        n_total++;
        if ({cs_n, wr_n, rd_n, busy, wr_ready} !== 5'b11100) $display("FAIL abort_outputs: cs/wr/rd/busy/rdy=%b, required 11100", {cs_n, wr_n, rd_n, busy, wr_ready});
        else n_pass++;
        @(negedge clk_host);
        ic_n = 1'b1;
        model_clear();
        repeat (3) @(negedge clk_host);
        n_total++;
        if (rd_done_cnt != done0 || busy !== 1'b0) $display("FAIL abort_quiet: pulses=%0d busy=%b, required 0 and 0", rd_done_cnt - done0, busy);
        else n_pass++;
        obs_q.delete();
        do_write(1'b0, 8'h40, 8'h99, hit, occ);
        n_total++;
        if (hit || obs_q.size() != 2 || occ != 2 * PH) $display("FAIL abort_next_write: runs=%0d occ=%0d, required 2 and %0d", obs_q.size(), occ, 2 * PH);
        else n_pass++;
    endtask

    task automatic test_addr_repeat();
        bit hit;
        int occ;
        int exp_runs[3];
        obs_q.delete();
        do_write(1'b0, 8'hA0, 8'h11, hit, occ);
        do_write(1'b0, 8'hA0, 8'h22, hit, occ);
        exp_runs[0] = obs_q.size();
        n_total++;
`ifdef OPL3_BUS_ADDR_CACHE_EN
        if (!hit || occ != PH || exp_runs[0] != 3) $display("FAIL repeat_cached: occ=%0d runs=%0d, required %0d and 3", occ, exp_runs[0], PH);
`else
        if (hit || occ != 2 * PH || exp_runs[0] != 4) $display("FAIL repeat_uncached: occ=%0d runs=%0d, required %0d and 4", occ, exp_runs[0], 2 * PH);
`endif
        else n_pass++;
        do_read(8'h06, occ);
        obs_q.delete();
        do_write(1'b0, 8'hA0, 8'h33, hit, occ);
        n_total++;
        if (hit || occ != 2 * PH || obs_q.size() != 2 || obs_q[0].dout !== 8'hA0)
            $display("FAIL repeat_after_read: occ=%0d runs=%0d, required %0d and 2", occ, obs_q.size(), 2 * PH);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  a1, a2;
        bit  h1, h2;
        int  t, occ;
        logic [7:0] ad;
        ad = 8'($urandom_range(0, 255));
        wait_ready();
        h1 = model_wr(1'b1, ad);
        wr_bank = 1'b1; wr_address = ad; wr_data = 8'h5A; wr_valid = 1'b1;
        a1 = cyc;
        @(negedge clk_host);
        h2 = model_wr(1'b1, ad ^ 8'h55);
        wr_address = ad ^ 8'h55; wr_data = 8'hA5;
        t = 0;
        while (wr_ready !== 1'b1 && t < 100) begin
            @(negedge clk_host);
            t++;
        end
        a2 = cyc;
        @(negedge clk_host);
        wr_valid = 1'b0;
        wait_idle(occ);
        n_total++;
        if (a2 - a1 != (h1 ? 1 : 2) * PH + 1) $display("FAIL b2b_spacing: got %0d, required %0d", a2 - a1, (h1 ? 1 : 2) * PH + 1);
        else n_pass++;
        n_total++;
        if (h2 || occ != 2 * PH) $display("FAIL b2b_second: occ=%0d, required %0d", occ, 2 * PH);
        else n_pass++;
    endtask

    task automatic test_random();
        bit         hit;
        int         occ, ne, done0;
        logic       b;
        logic [7:0] a, d;
        for (int i = 0; i < 40; i++) begin
            obs_q.delete();
            done0 = rd_done_cnt;
            if ($urandom_range(0, 2) == 0) begin
                d = 8'($urandom);
                do_read(d, occ);
                n_total++;
                if (occ != PH || obs_q.size() != 1 || rd_done_cnt - done0 != 1 || rd_seen !== d)
                    $display("FAIL rand%0d_read: occ=%0d runs=%0d data=%h, required %0d 1 %h", i, occ, obs_q.size(), rd_seen, PH, d);
                else n_pass++;
            end else begin
                b = 1'($urandom);
                a = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'($urandom);
                d = 8'($urandom);
                do_write(b, a, d, hit, occ);
                ne = hit ? 1 : 2;
                n_total++;
                if (occ != ne * PH || obs_q.size() != ne || rd_done_cnt != done0)
                    $display("FAIL rand%0d_write_shape: occ=%0d runs=%0d, required %0d and %0d", i, occ, obs_q.size(), ne * PH, ne);
                else n_pass++;
                for (int k = 0; k < obs_q.size() && k < ne; k++) begin
                    logic [1:0] ea = {b, (hit || k == 1)};
                    logic [7:0] ed = (hit || k == 1) ? d : a;
                    n_total++;
                    if (!obs_q[k].is_wr || obs_q[k].addr !== ea || obs_q[k].dout !== ed || obs_q[k].len != T)
                        $display("FAIL rand%0d_cycle%0d: addr=%b dout=%h len=%0d, required %b %h %0d", i, k, obs_q[k].addr, obs_q[k].dout, obs_q[k].len, ea, ed, T);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (unstable != 0) $display("FAIL strobe_stability: %0d cycles changed address/dout under strobe, required 0", unstable);
        else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk_host);
        test_reset();
        test_write_cases();
        test_read();
        test_simultaneous();
        test_reset_abort();
        test_addr_repeat();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk_host);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
